// File: rtl/row_assembler_pkg.sv
// rtl/row_assembler_pkg.sv - shared defaults, FSM state type and row packing for row_assembler
package row_assembler_pkg;

  localparam int NUM_COLUMNS_DEF = 3;
  localparam int DATA_WIDTH_DEF  = 8;

  // Packing works on fixed-size slots so every geometry up to these limits shares one function.
  localparam int MAX_COLUMNS    = 16;
  localparam int MAX_DATA_WIDTH = 32;
  localparam int ROW_IDX_W      = $clog2(MAX_COLUMNS * MAX_DATA_WIDTH);
  localparam int COL_IDX_W      = $clog2(MAX_COLUMNS);
  localparam int BIT_IDX_W      = $clog2(MAX_DATA_WIDTH);

  typedef enum logic [1:0] {ST_FILL, ST_HOLD, ST_FULL} state_e;

  typedef logic [MAX_DATA_WIDTH-1:0]             elem_slot_t;
  typedef logic [MAX_COLUMNS*MAX_DATA_WIDTH-1:0] row_slot_t;

  function automatic row_slot_t pack_row(input elem_slot_t elems [MAX_COLUMNS],
                                         input int num_cols, input int data_width);
    row_slot_t row;
    row = '0;
    for (int c = 0; c < MAX_COLUMNS; c++) begin
      for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
        if (c < num_cols && b < data_width) begin
          row[ROW_IDX_W'(c * data_width + b)] = elems[COL_IDX_W'(c)][BIT_IDX_W'(b)];
        end
      end
    end
    return row;
  endfunction

endpackage

// File: rtl/write_index_counter.sv
// rtl/write_index_counter.sv - wrapping 0..NUM_COLUMNS-1 column pointer with a last-column flag
module write_index_counter #(
  parameter int NUM_COLUMNS = 3,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clear,
  output logic [INDEX_WIDTH-1:0] count,
  output logic                   will_wrap
);

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_COLUMNS - 1);

  logic [INDEX_WIDTH-1:0] count_q, count_d;

  assign will_wrap = (count_q == LAST);
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = will_wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/row_assembler.sv
// rtl/row_assembler.sv - packs NUM_COLUMNS serial elements into one row word behind a valid/ready output
// Define ROW_ASSEMBLER_DOUBLE_BUFFER_EN for a separate output register so filling continues while a row waits.
module row_assembler
  import row_assembler_pkg::*;
#(
  parameter int NUM_COLUMNS = NUM_COLUMNS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic [INDEX_WIDTH-1:0]            column_index,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_COLUMNS*DATA_WIDTH-1:0] out_row,
  output logic                              row_done
);

  localparam int ROW_W = NUM_COLUMNS * DATA_WIDTH;

  state_e           state_q;
  logic             out_valid_q;
  logic             accept;
  logic             will_wrap;
  elem_slot_t       slots [MAX_COLUMNS];
  logic [ROW_W-1:0] row_packed;

  assign in_ready  = (state_q == ST_FILL);
  assign accept    = in_valid && in_ready;
  assign row_done  = accept && will_wrap && !clear;
  assign out_valid = out_valid_q;

  write_index_counter #(
    .NUM_COLUMNS(NUM_COLUMNS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_index (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (accept),
    .clear    (clear),
    .count    (column_index),
    .will_wrap(will_wrap)
  );

  for (genvar c = 0; c < NUM_COLUMNS; c++) begin : g_col
    logic [DATA_WIDTH-1:0] elem_q;
    logic                  wr;

    assign wr = accept && (column_index == INDEX_WIDTH'(c));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        elem_q <= '0;
      end else if (clear) begin
        elem_q <= '0;
      end else if (wr) begin
        elem_q <= in_data;
      end
    end

`ifdef ROW_ASSEMBLER_DOUBLE_BUFFER_EN
    // The copy into the output register must already see the element accepted this cycle.
    assign slots[c] = elem_slot_t'(wr ? in_data : elem_q);
`else
    assign slots[c] = elem_slot_t'(elem_q);
`endif
  end

  for (genvar s = NUM_COLUMNS; s < MAX_COLUMNS; s++) begin : g_pad
    assign slots[s] = '0;
  end

  assign row_packed = ROW_W'(pack_row(slots, NUM_COLUMNS, DATA_WIDTH));

`ifdef ROW_ASSEMBLER_DOUBLE_BUFFER_EN
  logic [ROW_W-1:0] out_row_q;
  logic             drain;

  assign drain   = out_valid_q && out_ready;
  assign out_row = out_row_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FILL;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else if (clear) begin
      state_q     <= ST_FILL;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (drain) out_valid_q <= 1'b0;
          if (accept && will_wrap) begin
            if (!out_valid_q || out_ready) begin
              out_row_q   <= row_packed;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_row_q <= row_packed;
            state_q   <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end
`else
  assign out_row = row_packed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FILL;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_FILL;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept && will_wrap) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_FILL;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_row_assembler.sv
// tb/tb_row_assembler.sv - directed and randomized checks of row_assembler against a queue-based row model
module tb_row_assembler;

  localparam int N  = 3;
  localparam int DW = 8;

  logic        clock = 1'b0;
  logic        reset_n, clear, in_valid, in_ready, out_valid, out_ready, row_done;
  logic [7:0]  in_data;
  logic [1:0]  column_index;
  logic [23:0] out_row;

  int checks   = 0;
  int failures = 0;
  int exp_col;
  int rows;

  logic [7:0]  part [$];
  logic        m_hold, m_out_full, m_blocked, last_accept;
  logic [23:0] m_out_row, m_block_row;
  logic        exp_ready, exp_valid;
  logic [7:0]  gdata [5];
  logic        gval  [5];

  always #5 clock = ~clock;

  row_assembler #(.NUM_COLUMNS(N), .DATA_WIDTH(DW), .INDEX_WIDTH(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .column_index(column_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .row_done    (row_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] model_pack();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < part.size(); i++) r[i*DW +: DW] = part[i];
    return r;
  endfunction

  function automatic logic m_in_ready();
`ifdef ROW_ASSEMBLER_DOUBLE_BUFFER_EN
    return !m_blocked;
`else
    return !m_hold;
`endif
  endfunction

  function automatic logic m_out_valid();
`ifdef ROW_ASSEMBLER_DOUBLE_BUFFER_EN
    return m_out_full;
`else
    return m_hold;
`endif
  endfunction

  task automatic model_reset();
    part.delete();
    m_hold = 0; m_out_full = 0; m_blocked = 0; last_accept = 1;
    m_out_row = '0; m_block_row = '0;
  endtask

  // Applies the effect of the coming clock edge, given the inputs currently driven.
  task automatic model_edge();
    logic        acc, old_full;
    logic [23:0] row;
    acc = in_valid && m_in_ready();
    old_full = m_out_full;
    if (clear) begin
      model_reset();
      return;
    end
    last_accept = acc;
`ifdef ROW_ASSEMBLER_DOUBLE_BUFFER_EN
    if (m_blocked) begin
      if (out_ready) begin
        m_out_row = m_block_row;
        m_blocked = 0;
      end
    end else begin
      if (old_full && out_ready) m_out_full = 0;
      if (acc) begin
        part.push_back(in_data);
        if (part.size() == N) begin
          row = model_pack();
          part.delete();
          if (!old_full || out_ready) begin
            m_out_row  = row;
            m_out_full = 1;
          end else begin
            m_block_row = row;
            m_blocked   = 1;
          end
        end
      end
    end
`else
    if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (acc) begin
      part.push_back(in_data);
      if (part.size() == N) begin
        m_out_row = model_pack();
        part.delete();
        m_hold = 1;
      end
    end
`endif
  endtask

  initial begin
    reset_n = 0; clear = 0; in_valid = 0; out_ready = 0; in_data = 0;
    gdata = '{8'hA0, 8'hEE, 8'hB0, 8'hEE, 8'hC0};
    gval  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    model_reset();

    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_col", column_index, 0);
    check("rst_out_row", out_row, 0);
    check("rst_row_done", row_done, 0);
    tick();
    reset_n = 1;

`ifndef ROW_ASSEMBLER_DOUBLE_BUFFER_EN
    in_valid = 1; in_data = 8'h11;
    @(negedge clock);
    check("bf_ready", in_ready, 1);
    check("bf_done0", row_done, 0);
    tick(); in_data = 8'h22;
    @(negedge clock);
    check("bf_col1", column_index, 1);
    tick(); in_data = 8'h33;
    @(negedge clock);
    check("bf_done", row_done, 1);
    check("bf_col2", column_index, 2);
    tick(); in_valid = 0;
    @(negedge clock);
    check("bf_valid", out_valid, 1);
    check("bf_row", out_row, 24'h332211);
    check("bf_busy", in_ready, 0);
    check("bf_col0", column_index, 0);
    check("bf_done_pulse", row_done, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clock);
      check("bp_row", out_row, 24'h332211);
      check("bp_valid", out_valid, 1);
    end
    tick(); out_ready = 1;
    tick(); out_ready = 0;
    @(negedge clock);
    check("bp_drained", out_valid, 0);
    check("bp_ready", in_ready, 1);

    exp_col = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); in_valid = gval[i]; in_data = gdata[i];
      @(negedge clock);
      check("gap_col", column_index, exp_col);
      if (gval[i]) exp_col = (exp_col + 1) % N;
    end
    tick(); in_valid = 0;
    @(negedge clock);
    check("gap_col_end", column_index, 0);
    check("gap_row", out_row, 24'hC0B0A0);
    check("gap_valid", out_valid, 1);

    tick(); in_valid = 1; in_data = 8'hFF;
    @(negedge clock);
    check("hold_ready", in_ready, 0);
    check("hold_done", row_done, 0);
    tick(); in_valid = 0;
    @(negedge clock);
    check("hold_col", column_index, 0);
    check("hold_row", out_row, 24'hC0B0A0);
    tick(); out_ready = 1;
    tick(); out_ready = 0;

    tick(); in_valid = 1; in_data = 8'h01;
    tick(); in_data = 8'h02;
    tick(); in_data = 8'h03; clear = 1;
    @(negedge clock);
    check("clr_done", row_done, 0);
    tick(); clear = 0; in_valid = 0;
    @(negedge clock);
    check("clr_col", column_index, 0);
    check("clr_row", out_row, 0);
    check("clr_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); in_valid = 1; in_data = 8'(4 + i);
    end
    tick(); in_valid = 0;
    @(negedge clock);
    check("clr_next_row", out_row, 24'h060504);
    check("clr_next_valid", out_valid, 1);
    tick(); clear = 1;
    tick(); clear = 0;
    @(negedge clock);
    check("clr_hold_valid", out_valid, 0);
    check("clr_hold_ready", in_ready, 1);
    check("clr_hold_row", out_row, 0);

    tick(); in_valid = 1; in_data = 8'h07;
    tick(); in_data = 8'h08;
    tick(); in_data = 8'h09; clear = 1;
    @(negedge clock);
    check("clr_last_done", row_done, 0);
    tick(); clear = 0; in_valid = 0;
    @(negedge clock);
    check("clr_last_valid", out_valid, 0);
    check("clr_last_col", column_index, 0);

    tick(); in_valid = 1; in_data = 8'h5A;
    tick(); in_data = 8'h5B;
    tick(); in_valid = 0;
    #2 reset_n = 0;
    #1;
    check("arst_col", column_index, 0);
    check("arst_row", out_row, 0);
    check("arst_ready", in_ready, 1);
    check("arst_valid", out_valid, 0);
    tick(); reset_n = 1; in_valid = 1; in_data = 8'h77;
    tick(); in_valid = 0;
    @(negedge clock);
    check("arst_no_row", out_valid, 0);
    check("arst_col_after", column_index, 1);
`else
    out_ready = 1; rows = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); in_valid = (i < 6); in_data = 8'(i + 1);
      @(negedge clock);
      if (i < 6) check("db_stream_ready", in_ready, 1);
      if (out_valid) begin
        check("db_stream_row", out_row, (rows == 0) ? 24'h030201 : 24'h060504);
        rows++;
      end
    end
    check("db_stream_rows", rows, 2);
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); in_valid = 1; in_data = 8'(8'h0A + i);
      @(negedge clock);
      check("db_bp_ready", in_ready, 1);
    end
    tick(); in_valid = 0;
    @(negedge clock);
    check("db_full_ready", in_ready, 0);
    check("db_full_row", out_row, 24'h0C0B0A);
    check("db_full_valid", out_valid, 1);
    tick(); out_ready = 1;
    tick(); out_ready = 0;
    @(negedge clock);
    check("db_swap_row", out_row, 24'h0F0E0D);
    check("db_swap_ready", in_ready, 1);
    check("db_swap_valid", out_valid, 1);
    tick(); out_ready = 1;
    tick(); out_ready = 0;
    @(negedge clock);
    check("db_empty_valid", out_valid, 0);
`endif

    tick(); clear = 1; in_valid = 0; out_ready = 0;
    tick(); clear = 0;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      clear = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid || last_accept) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      @(negedge clock);
      exp_ready = m_in_ready();
      exp_valid = m_out_valid();
      check("rnd_in_ready", in_ready, exp_ready);
      check("rnd_out_valid", out_valid, exp_valid);
      check("rnd_col", column_index, part.size());
      check("rnd_row_done", row_done, !clear && in_valid && exp_ready && (part.size() == N - 1));
      if (exp_valid) check("rnd_out_row", out_row, m_out_row);
      model_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
